// File: rtl/rx_buffer_pkg.sv
// Shared definitions for the RX packet buffer: word width, write-sequencer
// states, debug_bus field layout and a small channel-count helper.
package rx_buffer_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1
    } seq_state_e;

    localparam int DBG_FILL_LSB  = 0;
    localparam int DBG_SCLK_BIT  = 8;
    localparam int DBG_CS_BIT    = 9;
    localparam int DBG_BCNT_LSB  = 10;
    localparam int DBG_STATE_LSB = 14;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        popcount4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

// File: rtl/rx_spi_slave.sv
// Mode-0 SPI slave oversampled in the rx_clk domain; requests FIFO words and
// shifts them out MSB first on spi_miso.
module rx_spi_slave
    import rx_buffer_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_clk,
    input  logic              spi_cs_n,
    output logic              spi_miso,
    output logic              pop_req,
    input  logic              pop_ack,
    input  logic [WORD_W-1:0] pop_data,
    output logic [3:0]        bit_cnt,
    output logic              cs_sync,
    output logic              sclk_sync
);

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q;
    logic                   sclk_prev_q, cs_prev_q;
    logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0]      shift_q, shift_d, next_q;
    logic                   cs_load_q;

    assign sclk_sync = sclk_sync_q[SYNC_STAGES-1];
    assign cs_sync   = cs_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_sync & ~sclk_prev_q & ~cs_sync;
    assign sclk_fall = ~sclk_sync & sclk_prev_q & ~cs_sync;
    assign cs_fall   = ~cs_sync & cs_prev_q;
    assign cs_rise   = cs_sync & ~cs_prev_q;

    // Prefetch on the 16th rise so the next word is ready for the following fall.
    assign pop_req  = cs_fall | (sclk_rise && bit_cnt_q == 4'd15);
    assign spi_miso = shift_q[WORD_W-1];
    assign bit_cnt  = bit_cnt_q;

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        if (cs_rise) begin
            bit_cnt_d = '0;
            shift_d   = '0;
        end else begin
            if (sclk_rise) bit_cnt_d = bit_cnt_q + 4'd1;
            if (sclk_fall) shift_d = (bit_cnt_q == 4'd0) ? next_q : {shift_q[WORD_W-2:0], 1'b0};
            if (pop_ack && cs_load_q) shift_d = pop_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            cs_load_q   <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
            sclk_prev_q <= sclk_sync;
            cs_prev_q   <= cs_sync;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            cs_load_q   <= cs_fall;
        end
    end

    always_ff @(posedge clk) begin
        if (pop_ack) next_q <= pop_data;
    end

endmodule

// File: rtl/rx_pkt_buffer.sv
// Captures enabled ADC channels into an interleaved circular FIFO and drains
// it to the host through the oversampled SPI slave.
module rx_pkt_buffer
    import rx_buffer_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int SAMPLE_W    = 12,
    parameter int DEPTH       = 1024,
    parameter int PKT_WORDS   = 256,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       rx_clk,
    input  logic                       reset_n,
    input  logic                       rxstrobe,
    input  logic [NUM_CH-1:0]          ch_en,
    input  logic [NUM_CH*SAMPLE_W-1:0] ch_data,
    input  logic                       clear_status,
    input  logic                       spi_clk,
    input  logic                       spi_cs_n,
    output logic                       spi_miso,
    output logic                       have_pkt_rdy,
    output logic                       rx_overrun,
    output logic                       rx_underrun,
    output logic [$clog2(DEPTH):0]     fill_level,
    output logic [15:0]                debug_bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;

    function automatic logic [WORD_W-1:0] sext(input logic [SAMPLE_W-1:0] s);
        logic signed [SAMPLE_W-1:0] ss;
        ss   = s;
        sext = WORD_W'(ss);
    endfunction

    logic [WORD_W-1:0]          mem [DEPTH];
    logic [AW-1:0]              wr_ptr_q, rd_ptr_q;
    logic [FW-1:0]              fill_q, fill_d;
    seq_state_e                 state_q, state_d;
    logic [NUM_CH-1:0]          rem_q, rem_d, cur_oh;
    logic [NUM_CH*SAMPLE_W-1:0] data_q;
    logic [WORD_W-1:0]          wr_word, rd_data_q;
    logic [2:0]                 n_new;
    logic                       wr_en, last_wr, can_take, fits, start, drop;
    logic                       pop_req, pop_ok, pop_ack_q;
    logic                       have_pkt_q, overrun_q, underrun_q;
    logic [3:0]                 bit_cnt;
    logic                       cs_sync, sclk_sync;

    assign n_new  = popcount4(4'(ch_en));
    assign cur_oh = rem_q & (-rem_q);
    assign last_wr = wr_en && ((rem_q & ~cur_oh) == '0);
    // The final write cycle can already accept the next frame, so strobes N apart are loss-free.
    assign can_take = (state_q == IDLE) || last_wr;
    assign fits  = (32'(fill_q) + 32'(wr_en) + 32'(n_new)) <= 32'(DEPTH);
    assign start = rxstrobe && can_take && (n_new != 3'd0) && fits;
    assign drop  = rxstrobe && (n_new != 3'd0) && (!can_take || !fits);

    always_ff @(posedge rx_clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = WRITE;
            WRITE:   if (last_wr) state_d = start ? WRITE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_en = (state_q == WRITE);
    end

    always_comb begin
        rem_d = rem_q;
        if (start)      rem_d = ch_en;
        else if (wr_en) rem_d = rem_q & ~cur_oh;
        wr_word = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (cur_oh[c]) wr_word = sext(data_q[c*SAMPLE_W +: SAMPLE_W]);
        end
    end

    assign pop_ok = pop_req && (fill_q != '0);
    assign fill_d = fill_q + FW'(wr_en) - FW'(pop_ok);

    always_ff @(posedge rx_clk or negedge reset_n) begin
        if (!reset_n) begin
            rem_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            pop_ack_q  <= 1'b0;
            have_pkt_q <= 1'b0;
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            rem_q      <= rem_d;
            fill_q     <= fill_d;
            pop_ack_q  <= pop_req;
            have_pkt_q <= (fill_q >= FW'(PKT_WORDS));
            if (wr_en)  wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
            overrun_q  <= drop | (overrun_q & ~clear_status);
            underrun_q <= (pop_req & ~pop_ok) | (underrun_q & ~clear_status);
        end
    end

    always_ff @(posedge rx_clk) begin
        if (start) data_q <= ch_data;
        if (wr_en) mem[wr_ptr_q] <= wr_word;
    end

    // An empty pop returns zero without touching the read pointer.
    always_ff @(posedge rx_clk) begin
        if (pop_req) rd_data_q <= pop_ok ? mem[rd_ptr_q] : '0;
    end

    rx_spi_slave #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_spi (
        .clk       (rx_clk),
        .rst_n     (reset_n),
        .spi_clk   (spi_clk),
        .spi_cs_n  (spi_cs_n),
        .spi_miso  (spi_miso),
        .pop_req   (pop_req),
        .pop_ack   (pop_ack_q),
        .pop_data  (rd_data_q),
        .bit_cnt   (bit_cnt),
        .cs_sync   (cs_sync),
        .sclk_sync (sclk_sync)
    );

    assign fill_level   = fill_q;
    assign have_pkt_rdy = have_pkt_q;
    assign rx_overrun   = overrun_q;
    assign rx_underrun  = underrun_q;

    always_comb begin
        debug_bus = '0;
        debug_bus[DBG_STATE_LSB +: 2] = state_q;
        debug_bus[DBG_BCNT_LSB +: 4]  = bit_cnt;
        debug_bus[DBG_CS_BIT]         = cs_sync;
        debug_bus[DBG_SCLK_BIT]       = sclk_sync;
        debug_bus[DBG_FILL_LSB +: 8]  = 8'(fill_q);
    end

endmodule

// File: tb/tb_rx_pkt_buffer.sv
// Directed bench for rx_pkt_buffer: a 1024-deep 12-bit instance (A) and a
// 16-deep 16-bit instance (B) share stimulus; each phase resets and checks one.
module tb_rx_pkt_buffer;

    logic        clk = 1'b0;
    logic        reset_n, rxstrobe, clear_status, spi_clk, spi_cs_n, sel_b;
    logic [1:0]  ch_en;
    logic [23:0] data_a;
    logic [31:0] data_b;
    logic        miso_a, miso_b, pkt_a, pkt_b, ovr_a, ovr_b, und_a, und_b;
    logic [10:0] fill_a;
    logic [4:0]  fill_b;
    logic [15:0] dbg_a, dbg_b;
    logic [15:0] w;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic [1:0]  en;
        logic [11:0] d0;
        logic [11:0] d1;
        int          n;
        logic [15:0] w0;
        logic [15:0] w1;
    } vec_t;
    vec_t tbl [7];

    always #5 clk = ~clk;

    rx_pkt_buffer #(.NUM_CH(2), .SAMPLE_W(12), .DEPTH(1024), .PKT_WORDS(256), .SYNC_STAGES(2)) u_a (
        .rx_clk(clk), .reset_n(reset_n), .rxstrobe(rxstrobe), .ch_en(ch_en), .ch_data(data_a),
        .clear_status(clear_status), .spi_clk(spi_clk), .spi_cs_n(spi_cs_n), .spi_miso(miso_a),
        .have_pkt_rdy(pkt_a), .rx_overrun(ovr_a), .rx_underrun(und_a), .fill_level(fill_a),
        .debug_bus(dbg_a));

    rx_pkt_buffer #(.NUM_CH(2), .SAMPLE_W(16), .DEPTH(16), .PKT_WORDS(8), .SYNC_STAGES(2)) u_b (
        .rx_clk(clk), .reset_n(reset_n), .rxstrobe(rxstrobe), .ch_en(ch_en), .ch_data(data_b),
        .clear_status(clear_status), .spi_clk(spi_clk), .spi_cs_n(spi_cs_n), .spi_miso(miso_b),
        .have_pkt_rdy(pkt_b), .rx_overrun(ovr_b), .rx_underrun(und_b), .fill_level(fill_b),
        .debug_bus(dbg_b));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [1:0] en, input logic [23:0] da, input logic [31:0] db);
        ch_en    = en;
        data_a   = da;
        data_b   = db;
        rxstrobe = 1'b1;
        cyc(1);
        rxstrobe = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_status = 1'b1;
        cyc(1);
        clear_status = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cyc(2);
        reset_n = 1'b1;
        cyc(2);
    endtask

    task automatic cs_low();
        spi_cs_n = 1'b0;
        cyc(8);
    endtask

    task automatic cs_high();
        cyc(5);
        spi_cs_n = 1'b1;
        cyc(6);
    endtask

    task automatic spi_word(input int nbits, output logic [15:0] wo);
        wo = '0;
        for (int i = 0; i < nbits; i++) begin
            cyc(5);
            wo = {wo[14:0], (sel_b ? miso_b : miso_a)};
            spi_clk = 1'b1;
            cyc(5);
            spi_clk = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_fill;
        int k;
        tbl[0] = '{2'b11, 12'h801, 12'h7FF, 2, 16'hF801, 16'h07FF};
        tbl[1] = '{2'b10, 12'h123, 12'h800, 1, 16'hF800, 16'h0000};
        tbl[2] = '{2'b01, 12'h7FF, 12'h000, 1, 16'h07FF, 16'h0000};
        tbl[3] = '{2'b00, 12'hFFF, 12'hFFF, 0, 16'h0000, 16'h0000};
        tbl[4] = '{2'b10, 12'h000, 12'hFFF, 1, 16'hFFFF, 16'h0000};
        tbl[5] = '{2'b11, 12'h000, 12'h001, 2, 16'h0000, 16'h0001};
        tbl[6] = '{2'b10, 12'h5A5, 12'h3C3, 1, 16'h03C3, 16'h0000};

        reset_n = 1'b0; rxstrobe = 1'b0; clear_status = 1'b0; spi_clk = 1'b0;
        spi_cs_n = 1'b1; sel_b = 1'b0; ch_en = '0; data_a = '0; data_b = '0;
        cyc(3);
        check("rst_fill_a", 32'(fill_a), 0);
        check("rst_pkt_a", 32'(pkt_a), 0);
        check("rst_ovr_a", 32'(ovr_a), 0);
        check("rst_und_a", 32'(und_a), 0);
        check("rst_miso_a", 32'(miso_a), 0);
        check("rst_dbg_a", 32'(dbg_a), 32'h0200);
        check("rst_fill_b", 32'(fill_b), 0);
        reset_n = 1'b1;
        cyc(2);

        // 128 interleaved frames, then a full 256-word drain
        for (int f = 0; f < 127; f++) begin
            strobe(2'b11, {12'h7FF, 12'h801}, 32'h0);
            cyc(3);
        end
        check("fill_254", 32'(fill_a), 254);
        check("pkt_below", 32'(pkt_a), 0);
        strobe(2'b11, {12'h7FF, 12'h801}, 32'h0);
        k = 0;
        while (fill_a != 11'd256 && k < 10) begin
            cyc(1);
            k++;
        end
        check("fill_256", 32'(fill_a), 256);
        check("pkt_lag", 32'(pkt_a), 0);
        cyc(1);
        check("pkt_rise", 32'(pkt_a), 1);
        check("ovr_none", 32'(ovr_a), 0);
        cs_low();
        check("fill_after_pop", 32'(fill_a), 255);
        check("pkt_fall", 32'(pkt_a), 0);
        for (int i = 0; i < 256; i++) begin
            spi_word(16, w);
            check($sformatf("stream_w%0d", i), 32'(w), (i % 2 == 0) ? 32'hF801 : 32'h07FF);
        end
        cs_high();
        check("drain_fill", 32'(fill_a), 0);
        check("drain_und", 32'(und_a), 1);
        pulse_clear();
        check("clr_und", 32'(und_a), 0);

        // table-driven channel-enable patterns
        exp_fill = 0;
        for (int i = 0; i < 7; i++) begin
            strobe(tbl[i].en, {tbl[i].d1, tbl[i].d0}, 32'h0);
            cyc(3);
            exp_fill += tbl[i].n;
            check($sformatf("tbl_fill%0d", i), 32'(fill_a), 32'(exp_fill));
        end
        cs_low();
        for (int i = 0; i < 7; i++) begin
            if (tbl[i].n >= 1) begin
                spi_word(16, w);
                check($sformatf("tbl_w0_%0d", i), 32'(w), 32'(tbl[i].w0));
            end
            if (tbl[i].n == 2) begin
                spi_word(16, w);
                check($sformatf("tbl_w1_%0d", i), 32'(w), 32'(tbl[i].w1));
            end
        end
        cs_high();
        check("tbl_empty", 32'(fill_a), 0);
        pulse_clear();

        // strobes one cycle apart: second frame dropped whole
        strobe(2'b11, {12'h222, 12'h111}, 32'h0);
        strobe(2'b11, {12'h444, 12'h333}, 32'h0);
        cyc(4);
        check("close_ovr", 32'(ovr_a), 1);
        check("close_fill", 32'(fill_a), 2);
        cs_low();
        spi_word(16, w);
        check("close_w0", 32'(w), 32'h0111);
        spi_word(16, w);
        check("close_w1", 32'(w), 32'h0222);
        cs_high();

        // reset mid-transfer with fill 40 and both sticky flags set
        for (int f = 0; f < 19; f++) begin
            strobe(2'b11, {12'h7FF, 12'h801}, 32'h0);
            cyc(3);
        end
        strobe(2'b11, {12'h7FF, 12'h801}, 32'h0);
        strobe(2'b11, {12'h7FF, 12'h801}, 32'h0);
        cyc(4);
        check("pre_rst_fill", 32'(fill_a), 40);
        check("pre_rst_ovr", 32'(ovr_a), 1);
        check("pre_rst_und", 32'(und_a), 1);
        cs_low();
        spi_word(3, w);
        cyc(4);
        check("pre_rst_miso", 32'(miso_a), 1);
        reset_n = 1'b0;
        #2;
        check("mid_rst_fill", 32'(fill_a), 0);
        check("mid_rst_miso", 32'(miso_a), 0);
        check("mid_rst_ovr", 32'(ovr_a), 0);
        check("mid_rst_und", 32'(und_a), 0);
        check("mid_rst_pkt", 32'(pkt_a), 0);
        spi_cs_n = 1'b1;
        spi_clk  = 1'b0;
        cyc(2);
        reset_n = 1'b1;
        cyc(2);
        strobe(2'b11, {12'h456, 12'h123}, 32'h0);
        cyc(3);
        check("post_rst_fill", 32'(fill_a), 2);
        cs_low();
        spi_word(16, w);
        check("post_rst_w0", 32'(w), 32'h0123);
        spi_word(16, w);
        check("post_rst_w1", 32'(w), 32'h0456);
        cs_high();

        // instance B: full FIFO drops frame 9, clear and clear-vs-set
        sel_b = 1'b1;
        do_reset();
        for (int f = 0; f < 8; f++) begin
            strobe(2'b11, 24'h0, {16'(16'h1001 + 2 * f), 16'(16'h1000 + 2 * f)});
            cyc(3);
        end
        check("b_fill16", 32'(fill_b), 16);
        check("b_ovr0", 32'(ovr_b), 0);
        check("b_pkt", 32'(pkt_b), 1);
        strobe(2'b11, 24'h0, {16'hDEAD, 16'hBEEF});
        cyc(3);
        check("b_drop_fill", 32'(fill_b), 16);
        check("b_drop_ovr", 32'(ovr_b), 1);
        pulse_clear();
        check("b_clr_ovr", 32'(ovr_b), 0);
        ch_en = 2'b11;
        rxstrobe = 1'b1;
        clear_status = 1'b1;
        cyc(1);
        rxstrobe = 1'b0;
        clear_status = 1'b0;
        check("b_clr_vs_set", 32'(ovr_b), 1);
        cs_low();
        for (int i = 0; i < 16; i++) begin
            spi_word(16, w);
            check($sformatf("b_w%0d", i), 32'(w), 32'(16'h1000 + i));
        end
        cs_high();
        check("b_empty", 32'(fill_b), 0);

        // instance B: underrun and partial-word abort
        do_reset();
        strobe(2'b01, 24'h0, {16'h0000, 16'hABCD});
        cyc(3);
        check("u_fill1", 32'(fill_b), 1);
        cs_low();
        spi_word(16, w);
        check("u_w0", 32'(w), 32'hABCD);
        spi_word(16, w);
        check("u_w1", 32'(w), 32'h0000);
        spi_word(16, w);
        check("u_w2", 32'(w), 32'h0000);
        cs_high();
        check("u_flag", 32'(und_b), 1);
        check("u_fill0", 32'(fill_b), 0);
        strobe(2'b11, 24'h0, {16'h2222, 16'h1111});
        cyc(3);
        strobe(2'b01, 24'h0, {16'h0000, 16'h3333});
        cyc(3);
        check("p_fill3", 32'(fill_b), 3);
        cs_low();
        spi_word(7, w);
        check("p_7bits", 32'(w), 32'h0008);
        cs_high();
        check("p_fill2", 32'(fill_b), 2);
        cs_low();
        spi_word(16, w);
        check("p_next", 32'(w), 32'h2222);
        cs_high();
        check("p_fill0", 32'(fill_b), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_pkt_buffer.md
Name: rx_pkt_buffer

Overview:
- Parametrised successor to the single-purpose Beagle RX buffer.
- Captures NUM_CH ADC channels on rxstrobe and interleaves the enabled channels into one circular sample FIFO.
- Asserts a packet-ready flag once PKT_WORDS words are stored.
- Drains the FIFO to the Beagle host over an SPI slave (mode 0) that is oversampled in the rx_clk domain.
- Adds per-channel enables, a sticky overrun/underrun status and a fill-level output.

Parameters:
- NUM_CH, 2, number of input channels (1..4).
- SAMPLE_W, 12, input sample width (1..16); each sample is sign-extended to 16 bits.
- DEPTH, 1024, FIFO depth in 16-bit words; power of two.
- PKT_WORDS, 256, fill threshold for have_pkt_rdy (1..DEPTH).
- SYNC_STAGES, 2, synchroniser depth on the SPI inputs (>=2).

Ports:
- rx_clk  in  1  sample/system clock (64 MHz).
- reset_n  in  1  asynchronous, active-low reset.
- rxstrobe  in  1  one-cycle pulse: ch_data is valid.
- ch_en  in  NUM_CH  per-channel enable; sampled when rxstrobe is accepted.
- ch_data  in  NUM_CH*SAMPLE_W  channel samples; channel 0 in the LSBs.
- clear_status  in  1  one-cycle pulse; clears the sticky flags.
- spi_clk  in  1  host SCLK, asynchronous to rx_clk.
- spi_cs_n  in  1  host chip select, active low.
- spi_miso  out  1  serial data to host.
- have_pkt_rdy  out  1  fill_level >= PKT_WORDS.
- rx_overrun  out  1  sticky: a frame was dropped.
- rx_underrun  out  1  sticky: host read while the FIFO was empty.
- fill_level  out  $clog2(DEPTH)+1  words currently stored.
- debug_bus  out  16  {sequencer state[1:0], spi bit count[3:0], sync'd cs_n, sync'd sclk, fill_level[7:0]}.

Behaviour:
- Reset: FIFO emptied (pointers 0). spi_miso, have_pkt_rdy, rx_overrun, rx_underrun and fill_level all 0. debug_bus reflects these reset state values. The sequencer is IDLE and the SPI bit counter is 0.
- Write sequencer, states IDLE, WRITE:
  - IDLE, on rxstrobe: latch ch_data and ch_en, and compute N = popcount(ch_en).
  - N=0: stay IDLE; nothing is written.
  - free = DEPTH - fill_level < N: whole frame dropped, rx_overrun set, stay IDLE. Partial frames are never written, so channel alignment is preserved.
  - Otherwise go to WRITE.
  - WRITE: writes one word per cycle for the enabled channels in ascending index order. Returns to IDLE after N cycles.
  - rxstrobe arriving in WRITE: frame dropped, rx_overrun set, current frame completes normally.
  - Minimum strobe spacing for loss-free capture is N cycles.
- Sign extension: word = {{(16-SAMPLE_W){s[MSB]}}, s}.
- SPI inputs: spi_clk and spi_cs_n pass through SYNC_STAGES flops; edges are detected on the synchronised copies. Requirements: spi_clk <= rx_clk/8, and the host waits >= 6 rx_clk after CS falls before the first SCLK rise.
- SPI framing:
  - CS fall: pop the head word. The RAM read has 1-cycle latency. The word loads into a 16-bit shift register and spi_miso = bit 15 within 2 cycles of the synchronised CS fall.
  - Each synchronised SCLK fall: shift left; spi_miso = new MSB.
  - After the 16th SCLK rise of a word, pop the next word. It loads at the following SCLK fall, so continuous streaming needs no gap.
  - Empty FIFO at a pop: load 0x0000, no pointer change, set rx_underrun.
  - CS rise: bit counter cleared, spi_miso driven 0. A partially shifted word counts as consumed and is lost.
- Pointers and fill: simultaneous write and pop in one cycle leaves fill_level unchanged. Pointers wrap modulo DEPTH. fill_level ranges 0..DEPTH.
- have_pkt_rdy is registered; it updates the cycle after fill_level changes.
- Sticky flags:
  - clear_status clears both sticky flags.
  - If a set event coincides with clear_status, the flag ends up set.
- reset_n asserted mid-frame or mid-transfer aborts everything immediately and returns to the reset state.

Decomposition:
- Shared package rx_buffer_pkg: WORD_W=16, sequencer state enum {IDLE, WRITE}, and the debug_bus field offsets.
- One sub-module, rx_spi_slave: synchronisers, edge detect, bit counter, shift register, and the pop request/data handshake.
- FIFO RAM and pointers stay in the top module.

Test Plan:
- NUM_CH=2, ch_en=2'b11, strobes every 4 cycles with ch0=12'h801 and ch1=12'h7FF, 128 frames, then an SPI read of 256 words. Required: words alternate 0xF801, 0x07FF. have_pkt_rdy rises one cycle after fill reaches 256 and falls after the first word is popped.
- ch_en=2'b10: read returns only ch1 samples, in strobe order. ch_en=2'b00 with strobes: fill_level stays 0.
- DEPTH=16, 9 frames of 2 channels without reading: frame 9 is dropped whole, fill_level=16, rx_overrun=1. clear_status gives rx_overrun=0. Clear coinciding with a new drop leaves rx_overrun=1.
- Strobes 1 cycle apart with N=2: second strobe dropped, rx_overrun=1, first frame intact.
- SPI read of 3 words with 1 stored: 0xABCD, then 0x0000, 0x0000, rx_underrun=1, fill_level=0. CS raised after 7 bits: that word is lost and the next transfer returns the following word.
- reset_n pulsed low during a transfer with fill 40: fill_level=0, spi_miso=0, all flags 0. The next strobe is written at address 0 and read back correctly.
